fetch_unit: RTL



---
 rtl/fetch_unit_if.sv | 47 ++++
 rtl/fetch_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: redirect input, instruction-memory request/response
// channel and the decode-facing instruction handshake.
interface fetch_unit_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc_p_4;

    // The fetch unit drives requests and decode-side instructions.
    modport master (
        input  redirect,
        input  redirect_pc,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        output if_valid,
        input  if_ready,
        output if_inst,
        output if_pc,
        output if_pc_p_4
    );

    modport slave (
        output redirect,
        output redirect_pc,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_addr,
        output imem_resp_valid,
        output imem_resp_data,
        input  if_valid,
        output if_ready,
        input  if_inst,
        input  if_pc,
        input  if_pc_p_4
    );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch: credit-limited imem requests, a PC tag queue,
// an instruction FIFO towards decode, and redirect with stale-response drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0]   pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_nxt_c;
    logic [CW-1:0] drop_cnt;

    logic [31:0]   tag_q [DEPTH];
    logic [PW-1:0] tag_wr;
    logic [PW-1:0] tag_rd;

    logic [31:0]   fifo_inst [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] fifo_wr;
    logic [PW-1:0] fifo_rd;
    logic [CW-1:0] fifo_cnt;

    logic [SW-1:0] used_c;
    logic          req_valid_c;
    logic          fire_c;
    logic          resp_c;
    logic          drop_c;
    logic          push_c;
    logic          pop_c;
    logic          fifo_nonempty_c;

    // Credits cover both requests in flight and words already buffered.
    assign used_c          = SW'(inflight) + SW'(fifo_cnt);
    assign req_valid_c     = !bus.redirect && (used_c < SW'(DEPTH));
    assign fire_c          = req_valid_c && bus.imem_req_ready;
    assign resp_c          = bus.imem_resp_valid;
    assign drop_c          = resp_c && (bus.redirect || (drop_cnt != '0));
    assign push_c          = resp_c && !drop_c;
    assign fifo_nonempty_c = (fifo_cnt != '0);
    assign pop_c           = fifo_nonempty_c && bus.if_ready && !bus.redirect;

    always_comb begin
        inflight_nxt_c = inflight;
        if (fire_c && !resp_c) begin
            inflight_nxt_c = inflight + CW'(1);
        end else if (!fire_c && resp_c) begin
            inflight_nxt_c = inflight - CW'(1);
        end
    end

    // Control state: PC, credit counters, queue pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC & ALIGN_MASK;
            inflight <= '0;
            drop_cnt <= '0;
            tag_wr   <= '0;
            tag_rd   <= '0;
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (bus.redirect) begin
                pc <= bus.redirect_pc & ALIGN_MASK;
            end else if (fire_c) begin
                pc <= pc + 32'd4;
            end

            inflight <= inflight_nxt_c;

            // Everything still outstanding after a redirect is stale.
            if (bus.redirect) begin
                drop_cnt <= inflight - CW'(resp_c);
            end else if (resp_c && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end

            // Stale responses still consume their tag, keeping tags in order.
            if (fire_c) begin
                tag_wr <= tag_wr + PW'(1);
            end
            if (resp_c) begin
                tag_rd <= tag_rd + PW'(1);
            end

            if (bus.redirect) begin
                fifo_wr  <= '0;
                fifo_rd  <= '0;
                fifo_cnt <= '0;
            end else begin
                if (push_c) begin
                    fifo_wr <= fifo_wr + PW'(1);
                end
                if (pop_c) begin
                    fifo_rd <= fifo_rd + PW'(1);
                end
                fifo_cnt <= fifo_cnt + CW'(push_c) - CW'(pop_c);
            end
        end
    end

    // Payload storage needs no reset; validity lives in the counters.
    always_ff @(posedge clk) begin
        if (fire_c) begin
            tag_q[tag_wr] <= pc;
        end
        if (push_c) begin
            fifo_inst[fifo_wr] <= bus.imem_resp_data;
            fifo_pc[fifo_wr]   <= tag_q[tag_rd];
        end
    end

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_addr      = pc & ALIGN_MASK;
    assign bus.if_valid       = fifo_nonempty_c;
    assign bus.if_inst        = fifo_inst[fifo_rd];
    assign bus.if_pc          = fifo_pc[fifo_rd];
    assign bus.if_pc_p_4      = fifo_pc[fifo_rd] + 32'd4;

endmodule
